// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
//
// Purpose:
//   Two-master, one-slave Wishbone classic-cycle arbiter. It shares one slave
//   port between m0 (MIPS memory side) and m1 (debug/DMA loader).
//   - The grant is registered and held for the whole cyc burst.
//   - When both masters request, round-robin picks the winner.
//   - A per-transfer watchdog ends any stalled strobe with an error, so a
//     missing ack can never hang the master.
//
// Parameters:
//   AW      - address width
//   DW      - data width (sel width is DW/8)
//   TIMEOUT - stalled-strobe cycles before a forced error; 0 disables it
//
// Ports:
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   mN_adr_i/dat_i/we_i/sel_i       - master N request payload
//   mN_cyc_i/stb_i                  - master N cycle / strobe
//   mN_dat_o/ack_o/err_o            - master N response
//   s_adr_o/dat_o/we_o/sel_o        - slave request payload (owner's)
//   s_cyc_o/stb_o                   - slave cycle / strobe (owner's)
//   s_dat_i/ack_i/err_i             - slave response
//   grant_o                         - one-hot owner (bit0 m0, bit1 m1)
//   timeout_o                       - one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // master 0
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // slave
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    // status
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_nxt;
    logic          last, last_nxt;     // most recent owner: 0 = m0, 1 = m1
    logic [CW-1:0] wd_cnt;
    logic          wd_fire;
    logic          wd_clr;
    logic          own_cyc;
    logic          own_stb;

    // ------------------------------------------------------------------
    // State, round-robin memory and watchdog counter
    // ------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            last   <= 1'b1;            // m0 wins the first tie
            wd_cnt <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (wd_clr) wd_cnt <= '0;
            else        wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: arbitration in IDLE, hand-over when the owner drops cyc
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
                else if (m0_cyc_i)        state_nxt = GNT0;
                else if (m1_cyc_i)        state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slave-side request mux (owner's signals, zeros when idle)
    // ------------------------------------------------------------------
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        unique case (state)
            GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // A strobe without cyc is ignored; reset kills the request immediately.
    assign s_cyc_o = own_cyc & ~rst_i;
    assign s_stb_o = own_cyc & own_stb & ~rst_i;

    // ------------------------------------------------------------------
    // Watchdog: counts consecutive stalled strobe cycles. An ack or err in
    // the firing cycle masks the fire, so ack wins a tie with the timeout.
    // ------------------------------------------------------------------
    assign wd_fire = (TIMEOUT != 0) && (wd_cnt == WD_LAST) && s_stb_o
                     && !s_ack_i && !s_err_i;
    assign wd_clr  = (state == IDLE) || !s_stb_o || s_ack_i || s_err_i || wd_fire;

    // ------------------------------------------------------------------
    // Master-side responses
    // ------------------------------------------------------------------
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign m0_ack_o  = (state == GNT0) && s_ack_i && !rst_i;
    assign m1_ack_o  = (state == GNT1) && s_ack_i && !rst_i;
    assign m0_err_o  = (state == GNT0) && (s_err_i || wd_fire) && !rst_i;
    assign m1_err_o  = (state == GNT1) && (s_err_i || wd_fire) && !rst_i;
    assign timeout_o = wd_fire;
    assign grant_o   = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2
//
// Directed bench for wb_arbiter2. The main instance runs with TIMEOUT=4.
// A second instance with TIMEOUT=0 shares all inputs and is checked only
// in the long-stall scenario. Inputs are driven 1 time unit after the rising
// edge, and outputs are sampled 1 more unit later.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [AW-1:0]   m0_adr_i = '0, m1_adr_i = '0;
    logic [DW-1:0]   m0_dat_i = '0, m1_dat_i = '0;
    logic            m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [DW/8-1:0] m0_sel_i = '0, m1_sel_i = '0;
    logic            m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic            m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0;

    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic            s_we_o, s_cyc_o, s_stb_o, timeout_o;
    logic [DW/8-1:0] s_sel_o;
    logic [1:0]      grant_o;

    // outputs of the TIMEOUT=0 instance
    logic [DW-1:0]   z_m0_dat_o, z_m1_dat_o;
    logic            z_m0_ack_o, z_m1_ack_o, z_m0_err_o, z_m1_err_o;
    logic [AW-1:0]   z_s_adr_o;
    logic [DW-1:0]   z_s_dat_o;
    logic            z_s_we_o, z_s_cyc_o, z_s_stb_o, z_timeout_o;
    logic [DW/8-1:0] z_s_sel_o;
    logic [1:0]      z_grant_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(0)) dut_nt (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(z_m0_dat_o), .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(z_m1_dat_o), .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o),
        .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_we_o(z_s_we_o), .s_sel_o(z_s_sel_o),
        .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(z_grant_o), .timeout_o(z_timeout_o)
    );

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        m0_cyc_i = 1'b1;              // request during reset must not leak
        m0_stb_i = 1'b1;
        step();
        step();
        #1;
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b cyc=%b stb=%b ack0=%b err0=%b ack1=%b err1=%b to=%b, want all 0",
                     grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o);
        end
        m0_cyc_i = 1'b0;
        m0_stb_i = 1'b0;
        rst_i    = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        m0_adr_i = 32'h10;
        m0_cyc_i = 1'b1;
        m0_stb_i = 1'b1;
        #1;
        checks++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            errors++;
            $display("FAIL read_pre_grant: got grant=%b s_cyc=%b, want 00/0", grant_o, s_cyc_o);
        end
        step();                       // cycle 1 after request
        #1;
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o} !== 4'b0111 || s_adr_o !== 32'h10) begin
            errors++;
            $display("FAIL read_grant: got grant=%b cyc=%b stb=%b adr=%h, want 01/1/1/00000010",
                     grant_o, s_cyc_o, s_stb_o, s_adr_o);
        end
        step();                       // cycle 2: slave acks
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEADBEEF || m1_ack_o !== 1'b0 || grant_o !== 2'b01) begin
            errors++;
            $display("FAIL read_ack: got ack0=%b dat0=%h ack1=%b grant=%b, want 1/DEADBEEF/0/01",
                     m0_ack_o, m0_dat_o, m1_ack_o, grant_o);
        end
        step();
        s_ack_i  = 1'b0;
        m0_cyc_i = 1'b0;
        m0_stb_i = 1'b0;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin
            errors++;
            $display("FAIL read_release: got s_cyc=%b grant=%b, want 0/01", s_cyc_o, grant_o);
        end
        step();
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL read_idle: got grant=%b, want 00", grant_o);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        m0_adr_i = 32'h100;
        m1_adr_i = 32'h200;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        checks++;
        if (grant_o !== 2'b01 || s_adr_o !== 32'h100) begin
            errors++;
            $display("FAIL tie_first: got grant=%b adr=%h, want 01/00000100", grant_o, s_adr_o);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b01 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_drop: got grant=%b s_cyc=%b, want 01/0", grant_o, s_cyc_o);
        end
        step();
        checks++;
        if (grant_o !== 2'b10 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h200) begin
            errors++;
            $display("FAIL tie_handover: got grant=%b s_cyc=%b adr=%h, want 10/1/00000200",
                     grant_o, s_cyc_o, s_adr_o);
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL tie_idle: got grant=%b, want 00", grant_o);
        end
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL tie_second: got grant=%b, want 01", grant_o);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_grant_hold();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_ack_i = 1'b1;
            s_dat_i = 32'hA0 + i;
            #1;
            checks++;
            if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_dat_o !== 32'hA0 + i) begin
                errors++;
                $display("FAIL hold_beat%0d: got grant=%b ack1=%b ack0=%b dat1=%h, want 10/1/0/%h",
                         i, grant_o, m1_ack_o, m0_ack_o, m1_dat_o, 32'hA0 + i);
            end
            step();
        end
        s_ack_i  = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL hold_handover: got grant=%b, want 01", grant_o);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_watchdog();
        m0_we_i  = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();                       // stalled cycle 1
        for (int c = 1; c <= 12; c++) begin
            logic exp_err;
            logic exp_ack;
            if (c > 1) step();
            exp_ack = (c == 12);      // ack lands exactly in the firing cycle
            exp_err = (c == 4) || (c == 8);
            s_ack_i = exp_ack;
            #1;
            checks++;
            if (m0_err_o !== exp_err || timeout_o !== exp_err || m0_ack_o !== exp_ack || grant_o !== 2'b01) begin
                errors++;
                $display("FAIL watchdog_c%0d: got err=%b to=%b ack=%b grant=%b, want %b/%b/%b/01",
                         c, m0_err_o, timeout_o, m0_ack_o, grant_o, exp_err, exp_err, exp_ack);
            end
        end
        step();
        s_ack_i  = 1'b0;
        m0_we_i  = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        s_ack_i = 1'b1;
        #1;
        checks++;
        if (m1_ack_o !== 1'b1 || s_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got ack1=%b s_stb=%b, want 1/1", m1_ack_o, s_stb_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, timeout_o} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_force: got cyc=%b stb=%b ack1=%b err1=%b to=%b, want 0",
                     s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, timeout_o);
        end
        step();
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_grant: got grant=%b, want 00", grant_o);
        end
        rst_i   = 1'b0;
        s_ack_i = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: got grant=%b s_cyc=%b, want 00/0", grant_o, s_cyc_o);
        end
        step();
        checks++;
        if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_regrant: got grant=%b s_cyc=%b, want 10/1", grant_o, s_cyc_o);
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_no_timeout();
        apply_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        for (int c = 0; c < 1000; c++) begin
            #1;
            checks++;
            if ({z_grant_o, z_s_stb_o, z_m0_err_o, z_timeout_o} !== 5'b01100) begin
                errors++;
                $display("FAIL notimeout_c%0d: got grant=%b stb=%b err=%b to=%b, want 01/1/0/0",
                         c, z_grant_o, z_s_stb_o, z_m0_err_o, z_timeout_o);
            end
            step();
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_grant_hold();
        test_watchdog();
        test_reset_mid();
        test_no_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone classic-cycle arbiter that shares a single bus port between the MIPS memory-side master (`m0`) and a second master (`m1`, debug/DMA loader), ahead of `intercon`. Grant is registered and held for the full `cyc` burst. When both masters request, round-robin selection decides the winner. A per-transfer watchdog terminates any stalled slave access with an error, so a missing `ack` can never hang the pipeline's `wb_done` path.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `TIMEOUT`, 255, stalled-strobe cycles before a forced error; 0 disables the watchdog.

Ports:
- `clk_i` in 1: system clock; single clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `m0_adr_i`/`m1_adr_i` in AW: master address.
- `m0_dat_i`/`m1_dat_i` in DW: master write data.
- `m0_we_i`/`m1_we_i` in 1: write enable.
- `m0_sel_i`/`m1_sel_i` in DW/8: byte selects.
- `m0_cyc_i`/`m1_cyc_i` in 1: bus cycle request.
- `m0_stb_i`/`m1_stb_i` in 1: strobe.
- `m0_dat_o`/`m1_dat_o` out DW: read data (`s_dat_i` broadcast).
- `m0_ack_o`/`m1_ack_o` out 1: transfer acknowledge.
- `m0_err_o`/`m1_err_o` out 1: transfer error (slave error or watchdog).
- `s_adr_o` out AW, `s_dat_o` out DW, `s_we_o` out 1, `s_sel_o` out DW/8, `s_cyc_o` out 1, `s_stb_o` out 1: slave-side request.
- `s_dat_i` in DW, `s_ack_i` in 1, `s_err_i` in 1: slave response.
- `grant_o` out 2: one-hot current owner; bit0 = `m0`, bit1 = `m1`, `00` = idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states are `IDLE`, `GNT0` and `GNT1`, all registered. `last` records the most recent owner and resets to 1, so `m0` wins the first tie.
- `IDLE`:
  - Exactly one `mN_cyc_i` high → go to `GNTN`.
  - Both high → grant the master not equal to `last`.
  - Neither high → stay.
- `GNTN`:
  - All `s_*` outputs mux from master N combinationally.
  - `mN_ack_o = s_ack_i`, `mN_err_o = s_err_i | wd_fire`.
  - The non-owner's `ack_o`/`err_o` are 0.
  - `m*_dat_o = s_dat_i` always.
- Leaving `GNTN`: when `mN_cyc_i` is low, set `last <= N`.
  - If the other master's `cyc_i` is high, go directly to its grant state.
  - Otherwise go to `IDLE`.
  - In that cycle `s_cyc_o`/`s_stb_o` are 0, because owner `cyc` is low.
- In `IDLE`, all `s_*` control outputs are 0. `s_adr_o`/`s_dat_o`/`s_sel_o` are 0.
- Watchdog counter is `$clog2(TIMEOUT+1)` bits.
  - Clears in `IDLE`, when `s_stb_o` is 0, and on `s_ack_i | s_err_i`.
  - Otherwise increments by 1.
  - `wd_fire = (cnt == TIMEOUT-1) & s_stb_o & ~s_ack_i & ~s_err_i`.
  - On `wd_fire`: owner gets `err_o = 1`, `timeout_o` pulses, and the counter clears.
  - The grant is retained; the master decides whether to drop `cyc`.
- If `s_ack_i` and `wd_fire` would coincide, `ack` wins: `wd_fire` is masked and no error is raised.
- `s_ack_i` and `s_err_i` both high → pass both to the owner unchanged.
- Reset:
  - At the `rst_i` edge: state `IDLE`, `last = 1`, counter 0.
  - While `rst_i` is high, `s_cyc_o`, `s_stb_o`, all `ack_o`/`err_o` and `timeout_o` are forced 0 combinationally, including mid-transfer.
  - `grant_o = 00` after the edge.
- A master raising `stb` without `cyc` is ignored.

## Timing
- Grant latency is 1 cycle. `cyc` sampled high at edge k → `s_cyc_o` is high in cycle k+1 (from edge k).
- `ack`/`err`/data pass-through is 0 cycles (combinational).
- Handover is 1 cycle. Owner drops `cyc` in cycle t, next owner appears on the slave side in cycle t+1, with no `IDLE` bubble when the other master is already requesting.
- Watchdog fires in the TIMEOUT-th consecutive stalled cycle of a strobe. With TIMEOUT=4, `err_o` is seen in the 4th cycle after `s_stb_o` rises with no `ack`.
- With TIMEOUT=0, `wd_fire` is constantly 0.
- Outputs after reset: all 0, `grant_o = 00`.

## Test plan
1. **Single master read.** `m0` raises `cyc`/`stb`, `adr=0x10`; slave acks in cycle 2 with `dat=0xDEADBEEF`. Required: `s_cyc_o` high 1 cycle after the request, `m0_ack_o=1` with `m0_dat_o=0xDEADBEEF` in the same cycle, `m1_ack_o=0`, `grant_o=01`.
2. **Tie after reset.** Both masters raise `cyc` in the same cycle. Required: `m0` granted first. When `m0` drops `cyc`, `grant_o` goes `01→10` on the next cycle with no idle gap. A subsequent simultaneous tie goes to `m0`, because `last=1`.
3. **Grant hold.** `m1` owns and performs a 3-beat `cyc` burst while `m0` requests. Required: `grant_o` stays `10` for all 3 acks, and `m0_ack_o` stays 0 throughout.
4. **Watchdog.** TIMEOUT=4, `m0` write, slave never acks. Required: `m0_err_o=1` and `timeout_o=1` for exactly one cycle in the 4th stalled cycle; counter restarts; no `ack` to `m0`. Repeat with `ack` arriving in exactly that cycle → `ack` passes, no `err`.
5. **Reset mid-transfer.** Assert `rst_i` while `m1` is strobing. Required: `s_cyc_o`/`s_stb_o`/`m1_ack_o` are 0 in the same cycle; after the edge `grant_o=00`. Once `rst_i` is released, a new `m1` request is granted with 1-cycle latency.
6. **TIMEOUT=0.** Stall for 1000 cycles. Required: no `err`, no `timeout_o`, and the grant is held the whole time.
